// File: rtl/difftest_pkg.sv
// Shared definitions for the difftest CSR restore path: CSR addresses,
// shadow-entry indices, the entry-to-address map and the FSM state type.
package difftest_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_SEPC     = 12'h141;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_STVAL    = 12'h143;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_STVEC    = 12'h105;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_SCAUSE   = 12'h142;
  localparam logic [11:0] CSR_SATP     = 12'h180;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_SSCRATCH = 12'h140;
  localparam logic [11:0] CSR_MIDELEG  = 12'h303;
  localparam logic [11:0] CSR_MEDELEG  = 12'h302;

  // Shadow entry indices; entry 0 is the privilege mode and has no CSR address.
  typedef enum logic [4:0] {
    DT_PRIV     = 5'd0,
    DT_MSTATUS  = 5'd1,
    DT_SSTATUS  = 5'd2,
    DT_MEPC     = 5'd3,
    DT_SEPC     = 5'd4,
    DT_MTVAL    = 5'd5,
    DT_STVAL    = 5'd6,
    DT_MTVEC    = 5'd7,
    DT_STVEC    = 5'd8,
    DT_MCAUSE   = 5'd9,
    DT_SCAUSE   = 5'd10,
    DT_SATP     = 5'd11,
    DT_MIP      = 5'd12,
    DT_MIE      = 5'd13,
    DT_MSCRATCH = 5'd14,
    DT_SSCRATCH = 5'd15,
    DT_MIDELEG  = 5'd16,
    DT_MEDELEG  = 5'd17
  } dt_idx_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_WRITE = 3'd2,
    ST_PRIV  = 3'd3,
    ST_DONE  = 3'd4
  } dt_state_e;

  // Entry index to CSR address; unmapped indices (including priv) return 0.
  function automatic logic [11:0] dt_csr_addr(input logic [4:0] idx);
    logic [11:0] a;
    a = 12'h000;
    case (idx)
      DT_MSTATUS:  a = CSR_MSTATUS;
      DT_SSTATUS:  a = CSR_SSTATUS;
      DT_MEPC:     a = CSR_MEPC;
      DT_SEPC:     a = CSR_SEPC;
      DT_MTVAL:    a = CSR_MTVAL;
      DT_STVAL:    a = CSR_STVAL;
      DT_MTVEC:    a = CSR_MTVEC;
      DT_STVEC:    a = CSR_STVEC;
      DT_MCAUSE:   a = CSR_MCAUSE;
      DT_SCAUSE:   a = CSR_SCAUSE;
      DT_SATP:     a = CSR_SATP;
      DT_MIP:      a = CSR_MIP;
      DT_MIE:      a = CSR_MIE;
      DT_MSCRATCH: a = CSR_MSCRATCH;
      DT_SSCRATCH: a = CSR_SSCRATCH;
      DT_MIDELEG:  a = CSR_MIDELEG;
      DT_MEDELEG:  a = CSR_MEDELEG;
      default:     a = 12'h000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of i_vec, plus an any-set flag.
module lowest_set_idx #(
  parameter int W  = 17,
  parameter int IW = 5
) (
  input  logic [W-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scan from the top down so the lowest set bit is the last one to assign.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/difftest_csr_restore.sv
// Replays harness-loaded shadow CSR values into the core's CSR write port
// while holding the core stalled; privilege mode is restored last.
//
// CSR write handshake: a write transfers on a cycle where csr_wr_valid and
// csr_wr_ready are both high at the rising edge. While valid is high and
// ready is low, address and data stay stable and valid does not drop.
module difftest_csr_restore
  import difftest_pkg::*;
#(
  parameter int NUM_ENT = 18,
  parameter int XLEN    = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  input  logic [4:0]      load_idx,
  input  logic [XLEN-1:0] load_data,
  output logic            load_ready,
  input  logic            start,
  input  logic            core_idle,
  output logic            hold_core,
  output logic            csr_wr_valid,
  output logic [11:0]     csr_wr_addr,
  output logic [XLEN-1:0] csr_wr_data,
  input  logic            csr_wr_ready,
  output logic            priv_wr_valid,
  output logic [1:0]      priv_wr_data,
  output logic            busy,
  output logic            done,
  output dt_state_e       dbg_state
);

  dt_state_e          r_state;
  logic [NUM_ENT-1:0] r_pend;
  logic [XLEN-1:0]    r_shadow [NUM_ENT];

  logic [4:0]         w_enc_idx;
  logic               w_any;
  logic [4:0]         w_cur_idx;
  logic               w_wr_valid;
  logic               w_accept;
  logic               w_load_ok;
  logic [NUM_ENT-1:0] w_clr_mask;
  logic [NUM_ENT-1:0] w_pend_after;

  // Lowest pending CSR entry; entry 0 (priv) is excluded and handled in PRIV.
  lowest_set_idx #(
    .W  (NUM_ENT - 1),
    .IW (5)
  ) u_enc (
    .i_vec (r_pend[NUM_ENT-1:1]),
    .o_idx (w_enc_idx),
    .o_any (w_any)
  );

  assign w_cur_idx  = w_enc_idx + 5'd1;
  assign w_wr_valid = (r_state == ST_WRITE) && w_any;
  assign w_accept   = w_wr_valid && csr_wr_ready;
  assign w_load_ok  = load_valid && (r_state == ST_IDLE) && (load_idx < 5'(NUM_ENT));

  // One-hot clear for the entry accepted this cycle, and the resulting pend set.
  always_comb begin
    w_clr_mask = '0;
    if (w_accept) w_clr_mask[w_cur_idx] = 1'b1;
    w_pend_after = r_pend & ~w_clr_mask;
  end

  // Shadow storage: written only by accepted loads in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENT; i++) r_shadow[i] <= '0;
    end else if (w_load_ok) begin
      r_shadow[load_idx] <= load_data;
    end
  end

  // Restore sequencer and pending bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load_ok) r_pend[load_idx] <= 1'b1;
          if (start) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (core_idle) r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_pend <= w_pend_after;
          if (w_pend_after[NUM_ENT-1:1] == '0) r_state <= ST_PRIV;
        end
        ST_PRIV: begin
          r_pend[0] <= 1'b0;
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are decodes of registered state only; WRITE address/data
  // follow the registered pend bits through the encoder.
  assign load_ready    = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign hold_core     = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);
  assign csr_wr_valid  = w_wr_valid;
  assign csr_wr_addr   = w_wr_valid ? dt_csr_addr(w_cur_idx) : 12'h000;
  assign csr_wr_data   = w_wr_valid ? r_shadow[w_cur_idx] : '0;
  assign priv_wr_valid = (r_state == ST_PRIV) && r_pend[0];
  assign priv_wr_data  = priv_wr_valid ? r_shadow[0][1:0] : 2'b00;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_difftest_csr_restore.sv
// Directed bench for difftest_csr_restore with a scoreboard of expected
// write/priv/done events popped by an independent monitor.
module tb_difftest_csr_restore;
  import difftest_pkg::*;

  localparam int W = 80;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic [4:0]  load_idx;
  logic [63:0] load_data;
  logic        load_ready;
  logic        start;
  logic        core_idle;
  logic        hold_core;
  logic        csr_wr_valid;
  logic [11:0] csr_wr_addr;
  logic [63:0] csr_wr_data;
  logic        csr_wr_ready;
  logic        priv_wr_valid;
  logic [1:0]  priv_wr_data;
  logic        busy;
  logic        done;
  dt_state_e   dbg_state;

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  difftest_csr_restore #(.NUM_ENT(18), .XLEN(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_valid    (load_valid),
    .load_idx      (load_idx),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .start         (start),
    .core_idle     (core_idle),
    .hold_core     (hold_core),
    .csr_wr_valid  (csr_wr_valid),
    .csr_wr_addr   (csr_wr_addr),
    .csr_wr_data   (csr_wr_data),
    .csr_wr_ready  (csr_wr_ready),
    .priv_wr_valid (priv_wr_valid),
    .priv_wr_data  (priv_wr_data),
    .busy          (busy),
    .done          (done),
    .dbg_state     (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required end before 200000");
    $fatal(1, "watchdog expired");
  end

  // Event encodings: kind 1 = CSR write, 2 = priv write, 3 = done pulse
  function automatic logic [W-1:0] ev_w(input logic [11:0] a, input logic [63:0] d);
    return {4'd1, a, d};
  endfunction
  function automatic logic [W-1:0] ev_p(input logic [1:0] p);
    return {4'd2, 12'd0, 62'd0, p};
  endfunction
  function automatic logic [W-1:0] ev_d();
    return {4'd3, 76'd0};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input logic [W-1:0] act);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_unexpected: got %h required no event", act);
    end else begin
      chk("sb_event", act, exp_q.pop_front());
    end
  endtask

  // Monitor: sample away from the active edge and score every output event
  always @(negedge clk) begin
    if (rst_n) begin
      if (csr_wr_valid && csr_wr_ready) sb_check(ev_w(csr_wr_addr, csr_wr_data));
      if (priv_wr_valid) sb_check(ev_p(priv_wr_data));
      if (done) sb_check(ev_d());
    end
  end

  // Driver: one load beat, entered and left at #1 after a rising edge
  task automatic do_load(input logic [4:0] idx, input logic [63:0] data);
    load_valid = 1'b1;
    load_idx   = idx;
    load_data  = data;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  // Driver: start a restore, optionally delay core_idle, stall one address,
  // and inject start/load at cycle inj_c; checks done latency from start.
  task automatic run_restore(input int exp_lat, input int idle_delay,
                             input logic [11:0] st_addr, input logic [63:0] st_data,
                             input int st_n, input int inj_c);
    int stalls;
    bit got;
    stalls = 0;
    got    = 1'b0;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      core_idle  = (c > idle_delay);
      start      = 1'b0;
      load_valid = 1'b0;
      if (c == inj_c) begin
        start      = 1'b1;
        load_valid = 1'b1;
        load_idx   = 5'd4;
        load_data  = 64'hBAD0_BAD0_BAD0_0004;
      end
      if (csr_wr_valid && csr_wr_addr == st_addr && stalls < st_n) begin
        csr_wr_ready = 1'b0;
        stalls++;
        chk("stall_addr", W'(csr_wr_addr), W'(st_addr));
        chk("stall_data", W'(csr_wr_data), W'(st_data));
      end else begin
        csr_wr_ready = 1'b1;
      end
      @(negedge clk);
      chk("hold_core_busy", W'(hold_core), W'(1));
      if (c <= idle_delay + 1) chk("drain_no_valid", W'(csr_wr_valid), W'(0));
      if (c == inj_c) chk("load_ready_busy", W'(load_ready), W'(0));
      if (done) begin
        chk("done_latency", W'(c), W'(exp_lat));
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done, required done at cycle %0d", exp_lat);
    end
    @(posedge clk); #1;
    start        = 1'b0;
    load_valid   = 1'b0;
    core_idle    = 1'b1;
    csr_wr_ready = 1'b1;
    chk("idle_after_done", W'({busy, load_ready}), W'(2'b01));
  endtask

  initial begin
    bit seen;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_idx = 5'd0;
    load_data = 64'd0;
    start = 1'b0;
    core_idle = 1'b1;
    csr_wr_ready = 1'b1;

    // Reset values
    #3;
    chk("rst_load_ready", W'(load_ready), W'(1));
    chk("rst_hold_core", W'(hold_core), W'(0));
    chk("rst_csr_wr_valid", W'(csr_wr_valid), W'(0));
    chk("rst_csr_wr_addr", W'(csr_wr_addr), W'(0));
    chk("rst_csr_wr_data", W'(csr_wr_data), W'(0));
    chk("rst_priv_wr_valid", W'(priv_wr_valid), W'(0));
    chk("rst_priv_wr_data", W'(priv_wr_data), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single CSR: mepc
    do_load(5'd3, 64'h0000_0000_8000_1234);
    exp_q.push_back(ev_w(12'h341, 64'h0000_0000_8000_1234));
    exp_q.push_back(ev_d());
    run_restore(4, 0, 12'h000, 64'd0, 0, 0);

    // Ordering and backpressure: 3 stall cycles on mcause
    do_load(5'd17, 64'h1700_0000_0000_0017);
    do_load(5'd1,  64'h0100_0000_0000_0001);
    do_load(5'd9,  64'h0900_0000_0000_0009);
    exp_q.push_back(ev_w(12'h300, 64'h0100_0000_0000_0001));
    exp_q.push_back(ev_w(12'h342, 64'h0900_0000_0000_0009));
    exp_q.push_back(ev_w(12'h302, 64'h1700_0000_0000_0017));
    exp_q.push_back(ev_d());
    run_restore(9, 0, 12'h342, 64'h0900_0000_0000_0009, 3, 0);

    // Privilege mode written after satp
    do_load(5'd0,  64'h0000_0000_0000_0003);
    do_load(5'd11, 64'h8000_0000_0008_0000);
    exp_q.push_back(ev_w(12'h180, 64'h8000_0000_0008_0000));
    exp_q.push_back(ev_p(2'd3));
    exp_q.push_back(ev_d());
    run_restore(4, 0, 12'h000, 64'd0, 0, 0);

    // Drain wait: core busy for 5 cycles
    do_load(5'd14, 64'hDEAD_BEEF_0000_0014);
    exp_q.push_back(ev_w(12'h340, 64'hDEAD_BEEF_0000_0014));
    exp_q.push_back(ev_d());
    run_restore(9, 5, 12'h000, 64'd0, 0, 0);

    // start and load of entry 4 during WRITE are ignored
    do_load(5'd2, 64'h0000_0000_0000_0055);
    exp_q.push_back(ev_w(12'h100, 64'h0000_0000_0000_0055));
    exp_q.push_back(ev_d());
    run_restore(6, 0, 12'h100, 64'h0000_0000_0000_0055, 2, 2);
    repeat (5) @(posedge clk);
    #1;
    chk("no_second_sequence", W'(busy), W'(0));

    // Out-of-range index in IDLE, then an empty restore: only done
    chk("load_ready_idle", W'(load_ready), W'(1));
    do_load(5'd20, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_q.push_back(ev_d());
    run_restore(4, 0, 12'h000, 64'd0, 0, 0);

    // Reset mid-restore during a stalled WRITE
    do_load(5'd5, 64'h0000_0000_0000_0077);
    csr_wr_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (csr_wr_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reached_write", W'(seen), W'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hold_core", W'(hold_core), W'(0));
    chk("rst_mid_busy", W'(busy), W'(0));
    chk("rst_mid_csr_wr_valid", W'(csr_wr_valid), W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    csr_wr_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(ev_d());
    run_restore(4, 0, 12'h000, 64'd0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", W'(exp_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/difftest_csr_restore.md
# difftest_csr_restore

Hardware-side writer for the difftest CSR set: the simulation harness loads reference-model CSR values into 18 shadow entries, then requests a restore. The block stalls the core, waits for the pipeline to drain, and replays every loaded entry into the core's CSR write port, one write per accepted handshake. It sits between the DPI shim in the simulation top and the core's CSR file. It is the inbound counterpart of the CSR state export used for comparison.

## Interface
- `NUM_ENT`, 18: number of shadow entries. Fixed by the CSR set; not to be overridden.
- `XLEN`, 64: CSR data width.
- `clk` input 1: clock.
- `rst_n` input 1: reset. Asynchronous, active-low.
- `load_valid` input 1: write `load_data` into entry `load_idx` and mark it pending.
- `load_idx` input 5: entry index. Values 0..17 are valid; 18..31 are ignored.
- `load_data` input XLEN: entry value.
- `load_ready` output 1: high only in IDLE.
- `start` input 1: one-cycle restore request.
- `core_idle` input 1: core pipeline is empty.
- `hold_core` output 1: stalls fetch and commit.
- `csr_wr_valid` output 1: CSR write request.
- `csr_wr_addr` output 12: CSR address.
- `csr_wr_data` output XLEN: CSR data.
- `csr_wr_ready` input 1: core accepts the write.
- `priv_wr_valid` output 1: one-cycle privilege-mode write.
- `priv_wr_data` output 2: new privilege mode, taken from entry 0 bits [1:0].
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse when the restore completes.

## Operation
- Entry map (index: CSR address): 0 priv (no CSR address), 1 mstatus 0x300, 2 sstatus 0x100, 3 mepc 0x341, 4 sepc 0x141, 5 mtval 0x343, 6 stval 0x143, 7 mtvec 0x305, 8 stvec 0x105, 9 mcause 0x342, 10 scause 0x142, 11 satp 0x180, 12 mip 0x344, 13 mie 0x304, 14 mscratch 0x340, 15 sscratch 0x140, 16 mideleg 0x303, 17 medeleg 0x302.
- `pend[17:0]` holds one pending bit per entry.
- Loads:
  - Accepted only when `load_valid && load_ready && load_idx<18`.
  - A reload of the same index overwrites the data; the pending bit stays set.
  - While busy, loads are dropped with no effect.
- FSM states: IDLE, DRAIN, WRITE, PRIV, DONE.
  - IDLE → DRAIN on `start`.
  - DRAIN → WRITE when `core_idle`.
  - In WRITE, `cur` is the lowest set bit of `pend[17:1]`.
    - `csr_wr_valid` = 1; address and data come from `cur`.
    - On `csr_wr_ready`, clear `pend[cur]`.
    - When `pend[17:1]` is zero, go to PRIV.
  - PRIV: if `pend[0]`, pulse `priv_wr_valid` and clear `pend[0]`. Always go to DONE. The privilege mode is written last so that all CSR writes use the old mode's permissions.
  - DONE: `done`=1 for one cycle, then IDLE.
- `hold_core` = 1 in every state except IDLE.
- `start` while busy is ignored.
- `start` with an empty `pend` still runs the full sequence: DRAIN → WRITE (no writes) → PRIV (no pulse) → DONE.
- `csr_wr_addr`/`csr_wr_data` hold stable while `csr_wr_valid && !csr_wr_ready`.

## Timing
- Reset values:
  - State = IDLE, `pend`=0, all shadow data = 0.
  - Outputs: `load_ready`=1, `hold_core`=0, `csr_wr_valid`=0, `csr_wr_addr`=0, `csr_wr_data`=0, `priv_wr_valid`=0, `priv_wr_data`=0, `busy`=0, `done`=0.
- All outputs are registered-state decodes: no combinational path from inputs to outputs, except that WRITE address/data follow `pend`, which is itself registered.
- `start` sampled at edge N:
  - `hold_core`=1 and `busy`=1 from cycle N+1.
  - Earliest first `csr_wr_valid` is cycle N+2, when `core_idle` is high at N+1.
- With `csr_wr_ready` tied high, k pending CSR entries take k cycles in WRITE. The next entry is presented in the cycle after the previous one is accepted.
- Full restore latency, with `core_idle` and `csr_wr_ready` both high: 1 (DRAIN) + max(k,1) (WRITE) + 1 (PRIV) + 1 (DONE) cycles after `start`.
- Async reset mid-restore:
  - Returns to IDLE immediately and clears `pend`.
  - `hold_core` drops without waiting for a clock edge.
  - Partially written CSRs are not rolled back.

## Structure
- Package `difftest_pkg`: CSR address localparams, the entry-index enum (`DT_PRIV`..`DT_MEDELEG`), the index→address lookup function, and the FSM state typedef.
- One sub-module, `lowest_set_idx`: a parameterised priority encoder over 17 bits, outputting a 5-bit index and an `any` flag.
- The shadow storage is a flat register array inside `difftest_csr_restore`. It is not a RAM macro.

## Test plan
- **Single CSR:** load idx 3 (mepc) = 0x8000_1234; `start`; `core_idle`=1; `ready`=1.
  - Expect exactly one write, addr 0x341, data 0x8000_1234.
  - Then PRIV with no pulse, then `done` 4 cycles after `start`.
- **Ordering and backpressure:** load idx 17, 1, 9.
  - Writes occur in order 0x300, 0x342, 0x302.
  - Hold `csr_wr_ready` low for 3 cycles on the 0x342 write: address and data stay stable.
- **Privilege mode last:** load idx 0 = 0x3 and idx 11 = 0x8000_0000_0008_0000.
  - The satp write completes before the one-cycle `priv_wr_valid` with `priv_wr_data`=3.
- **Drain wait:** `core_idle`=0 for 5 cycles after `start`.
  - `hold_core`=1 throughout; no `csr_wr_valid` until the cycle after `core_idle` rises.
- **Ignored inputs while busy:**
  - `start` and `load_valid` (idx 4) during WRITE: no second sequence runs, and entry 4 is not written.
  - `load_idx`=20 in IDLE: no entry changes.
- **Reset mid-restore:** assert `rst_n`=0 during WRITE.
  - `hold_core`, `busy` and `csr_wr_valid` are 0 immediately.
  - After release, a `start` with no loads produces only a `done` pulse 4 cycles later, with zero writes.
